// File: rtl/signal_head_driver.sv
// signal_head_driver: turns the controller's per-lane green requests into red/yellow/green
// lamp drives. It enforces a minimum green time, a fixed yellow time and an all-red
// clearance time for every lane.
// Optional feature: define SIGNAL_HEAD_WALK_EN to drive the walk lamps from walkReq.
// Without the macro, walk is tied low and walkReq is ignored.
module signal_head_driver #(
    parameter int unsigned LANES        = 8,
    parameter int unsigned TIMER_W      = 7,
    parameter int unsigned MIN_GREEN    = 5,
    parameter int unsigned YELLOW_TIME  = 3,
    parameter int unsigned ALL_RED_TIME = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LANES-1:0] greenReq,
    input  logic [LANES-1:0] walkReq,
    output logic [LANES-1:0] red,
    output logic [LANES-1:0] yellow,
    output logic [LANES-1:0] green,
    output logic [LANES-1:0] walk,
    output logic             clearing
);

    typedef enum logic [1:0] {StRed, StGreen, StYellow, StClear} lane_state_e;

    localparam logic [TIMER_W-1:0] CntOne     = TIMER_W'(1);
    localparam logic [TIMER_W-1:0] GreenLoad  = TIMER_W'(MIN_GREEN - 1);
    localparam logic [TIMER_W-1:0] YellowLoad = TIMER_W'(YELLOW_TIME - 1);
    localparam logic [TIMER_W-1:0] ClearLoad  = TIMER_W'((ALL_RED_TIME == 0) ? 0 : ALL_RED_TIME - 1);

    lane_state_e        r_state   [LANES];
    lane_state_e        w_state_d [LANES];
    logic [TIMER_W-1:0] r_cnt     [LANES];
    logic [TIMER_W-1:0] w_cnt_d   [LANES];

    logic             w_gate;
    logic [LANES-1:0] w_red_d, w_yellow_d, w_green_d, w_walk_d;
    logic             w_clearing_d;
    logic [LANES-1:0] r_red, r_yellow, r_green, r_walk;
    logic             r_clearing;

`ifndef SIGNAL_HEAD_WALK_EN
    logic w_unused_walk_req;
    assign w_unused_walk_req = ^walkReq;
`endif

    // Grant gate: no lane is yielding and no green lane has already been released.
    always_comb begin
        w_gate = 1'b1;
        for (int i = 0; i < LANES; i++) begin
            if (r_state[i] == StYellow || r_state[i] == StClear ||
                (r_state[i] == StGreen && !greenReq[i])) begin
                w_gate = 1'b0;
            end
        end
    end

    // Per-lane next state and interval counter.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            w_state_d[i] = r_state[i];
            w_cnt_d[i]   = r_cnt[i];
            unique case (r_state[i])
                StRed: begin
                    if (greenReq[i] && w_gate) begin
                        w_state_d[i] = StGreen;
                        w_cnt_d[i]   = GreenLoad;
                    end
                end
                StGreen: begin
                    if (r_cnt[i] == '0) begin
                        if (!greenReq[i]) begin
                            w_state_d[i] = StYellow;
                            w_cnt_d[i]   = YellowLoad;
                        end
                    end else begin
                        w_cnt_d[i] = r_cnt[i] - CntOne;
                    end
                end
                StYellow: begin
                    if (r_cnt[i] == '0) begin
                        w_state_d[i] = (ALL_RED_TIME == 0) ? StRed : StClear;
                        w_cnt_d[i]   = ClearLoad;
                    end else begin
                        w_cnt_d[i] = r_cnt[i] - CntOne;
                    end
                end
                StClear: begin
                    if (r_cnt[i] == '0) begin
                        w_state_d[i] = StRed;
                    end else begin
                        w_cnt_d[i] = r_cnt[i] - CntOne;
                    end
                end
                default: begin
                    w_state_d[i] = StRed;
                    w_cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // Lamp decode from next state, so the registered lamps track the state register exactly.
    always_comb begin
        w_red_d      = '0;
        w_yellow_d   = '0;
        w_green_d    = '0;
        w_walk_d     = '0;
        w_clearing_d = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            w_red_d[i]    = (w_state_d[i] == StRed) || (w_state_d[i] == StClear);
            w_yellow_d[i] = (w_state_d[i] == StYellow);
            w_green_d[i]  = (w_state_d[i] == StGreen);
            if (w_state_d[i] == StYellow || w_state_d[i] == StClear) begin
                w_clearing_d = 1'b1;
            end
`ifdef SIGNAL_HEAD_WALK_EN
            // Walk ends once the remaining green time no longer covers a yellow interval.
            w_walk_d[i] = (w_state_d[i] == StGreen) && walkReq[i] && (w_cnt_d[i] > YellowLoad);
`endif
        end
    end

    // State, counters and registered lamp outputs; reset forces all lanes to red at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LANES; i++) begin
                r_state[i] <= StRed;
                r_cnt[i]   <= '0;
            end
            r_red      <= '1;
            r_yellow   <= '0;
            r_green    <= '0;
            r_walk     <= '0;
            r_clearing <= 1'b0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                r_state[i] <= w_state_d[i];
                r_cnt[i]   <= w_cnt_d[i];
            end
            r_red      <= w_red_d;
            r_yellow   <= w_yellow_d;
            r_green    <= w_green_d;
            r_walk     <= w_walk_d;
            r_clearing <= w_clearing_d;
        end
    end

    assign red      = r_red;
    assign yellow   = r_yellow;
    assign green    = r_green;
    assign walk     = r_walk;
    assign clearing = r_clearing;

endmodule
